sdr_read_streamer: RTL and testbench
====================================

Name: sdr_read_streamer

Overview:
- Sits directly downstream of the SDRAM Avalon burst engine and drives its external read interface (baseaddr, nelems, readstart, readend, wide readdata).
- Accepts a read command of arbitrary length in 32-bit words and splits it into chunks of at most MAX_NREAD words.
- For each chunk, captures the engine's wide read vector and replays it as a one-word-per-cycle valid/ready stream to the raytracing pipeline (triangle/ray fetch).
- Read-only; the engine's write port is not driven by this block.

Parameters:
MAX_NREAD, 64, words per chunk; must equal the engine's MAX_NREAD
IDX_W, $clog2(MAX_NREAD)+1, width of the in-chunk word index/count

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_baseaddr  in  32  byte address of word 0, 4-byte aligned
cmd_nwords  in  30  total 32-bit words to fetch
sdr_baseaddr  out  32  chunk byte address to engine
sdr_nelems  out  30  chunk word count to engine
sdr_readstart  out  1  one-cycle start pulse to engine
sdr_readend  in  1  engine completion pulse; sdr_readdata valid this cycle
sdr_readdata  in  32*MAX_NREAD  engine read vector, word i at [32*i +: 32]
out_valid  out  1  stream word valid
out_ready  in  1  downstream accept
out_data  out  32  stream word
out_last  out  1  high with final word of the command
busy  out  1  high whenever not IDLE
done  out  1  one-cycle pulse when a command completes, including zero-length commands

Behaviour:
- Reset values: all state registers, chunk buffer and outputs are 0. FSM goes to IDLE, so cmd_ready=1 once reset deasserts.
- FSM states: IDLE, ISSUE, WAIT, DRAIN.
- IDLE, cmd_valid=1 (handshake cycle T):
  - latch base=cmd_baseaddr and remaining=cmd_nwords.
  - if cmd_nwords=0: pulse done at T+1, stay IDLE.
  - else go to ISSUE.
- ISSUE (one cycle):
  - sdr_readstart=1.
  - sdr_nelems=min(remaining,MAX_NREAD), registered as chunk_n; sdr_baseaddr=base.
  - go to WAIT.
  - sdr_readstart is never high two consecutive cycles, because the engine is level-sensitive in its idle state.
- sdr_baseaddr and sdr_nelems are registered and held stable from ISSUE until the cycle after sdr_readend, because the engine computes addresses from them continuously.
- WAIT:
  - on sdr_readend=1, copy sdr_readdata into the local buffer.
  - remaining -= chunk_n; base += 4*chunk_n (32-bit wrap, no error).
  - idx=0; go to DRAIN.
  - sdr_readend while not in WAIT is ignored.
- DRAIN:
  - out_valid=1, out_data=buffer[32*idx +: 32].
  - out_data is held stable while out_valid=1 and out_ready=0.
  - on out_ready: idx++.
  - on the handshake of idx=chunk_n-1: if remaining=0, go to IDLE and pulse done next cycle; else go to ISSUE.
- out_last=1 only when in DRAIN, idx=chunk_n-1 and remaining=0.
- Latency:
  - cmd handshake at T gives sdr_readstart at T+1.
  - readend at R gives first out_valid at R+1.
  - full throughput of one word/cycle within a chunk when out_ready is held high.
  - 1-cycle ISSUE bubble between chunks plus engine latency.
- cmd_valid while not IDLE is ignored; cmd_ready=0.
- Reset asserted mid-operation: immediate return to IDLE; out_valid, sdr_readstart and done go to 0; the buffer is cleared. The engine has its own reset and must be reset together with this block.
- Counters: remaining is 30 bits; chunk_n and idx are IDX_W bits. Handles MAX_NREAD equal to a power of two, and remaining equal to MAX_NREAD exactly (single full chunk, out_last on word MAX_NREAD-1).

Test Plan:
- cmd base=0x1000, nwords=3; engine returns words 0xA,0xB,0xC:
  - one sdr_readstart with sdr_nelems=3, sdr_baseaddr=0x1000.
  - stream 0xA,0xB,0xC on consecutive cycles, out_last on 0xC, done 1 cycle later.
- nwords=130, MAX_NREAD=64:
  - three chunks: nelems 64,64,2 at baseaddr 0x0,0x100,0x200.
  - 130 words in order, out_last only on word 129.
- Backpressure: out_ready pattern 1,0,0,1,0,1 during a 4-word chunk:
  - no word lost or duplicated.
  - out_data stable while stalled.
- nwords=0: cmd accepted, no sdr_readstart, no out_valid, done pulses 1 cycle after the handshake.
- cmd_valid held high during an active 5-word command: cmd_ready=0 until IDLE; the second command starts only after done.
- Reset low mid-DRAIN of a 64-word chunk (idx=10):
  - out_valid, busy and sdr_readstart go to 0 asynchronously.
  - after release, a new nwords=1 command works normally.

Source files
------------

// File: rtl/sdr_read_streamer.sv
// Read-side front end for the SDRAM Avalon burst engine: splits a word-count read
// command into engine-sized chunks and replays each captured chunk as a valid/ready stream.
module sdr_read_streamer #(
  parameter int MAX_NREAD = 64,
  parameter int IDX_W     = $clog2(MAX_NREAD) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [31:0]            cmd_baseaddr,
  input  logic [29:0]            cmd_nwords,
  output logic [31:0]            sdr_baseaddr,
  output logic [29:0]            sdr_nelems,
  output logic                   sdr_readstart,
  input  logic                   sdr_readend,
  input  logic [32*MAX_NREAD-1:0] sdr_readdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  localparam int               AW   = (MAX_NREAD > 1) ? $clog2(MAX_NREAD) : 1;
  localparam logic [29:0]      MAXW = 30'(MAX_NREAD);
  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [31:0]      r_base;
  logic [29:0]      r_remaining;
  logic [IDX_W-1:0] r_chunk_n;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_sdr_base;
  logic             r_done;
  logic [31:0]      r_buf [MAX_NREAD];

  logic             w_cmd_fire;
  logic             w_capture;
  logic             w_out_fire;
  logic             w_idx_last;
  logic             w_chunk_end;
  logic             w_final;

  function automatic logic [IDX_W-1:0] chunk_len(input logic [29:0] n);
    if (n >= MAXW) return IDX_W'(MAX_NREAD);
    return n[IDX_W-1:0];
  endfunction

  assign w_cmd_fire  = (r_state == S_IDLE) && cmd_valid;
  assign w_capture   = (r_state == S_WAIT) && sdr_readend;
  assign w_out_fire  = (r_state == S_DRAIN) && out_ready;
  assign w_idx_last  = (r_idx == (r_chunk_n - ONE));
  assign w_chunk_end = w_out_fire && w_idx_last;
  // remaining is already net of the chunk being drained
  assign w_final     = (r_remaining == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (cmd_valid && (cmd_nwords != '0)) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (sdr_readend) w_next = S_DRAIN;
      S_DRAIN: if (w_chunk_end) w_next = w_final ? S_IDLE : S_ISSUE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_base      <= '0;
      r_remaining <= '0;
      r_chunk_n   <= '0;
      r_idx       <= '0;
      r_sdr_base  <= '0;
      r_done      <= 1'b0;
      for (int i = 0; i < MAX_NREAD; i++) r_buf[i] <= '0;
    end else begin
      r_done <= (w_cmd_fire && (cmd_nwords == '0)) || (w_chunk_end && w_final);

      if (w_cmd_fire) begin
        r_base      <= cmd_baseaddr;
        r_remaining <= cmd_nwords;
        r_chunk_n   <= chunk_len(cmd_nwords);
        r_sdr_base  <= cmd_baseaddr;
      end

      // the engine address/length registers only move when a new chunk is issued
      if (w_capture) begin
        for (int i = 0; i < MAX_NREAD; i++) r_buf[i] <= sdr_readdata[32*i +: 32];
        r_remaining <= r_remaining - 30'(r_chunk_n);
        r_base      <= r_base + (32'(r_chunk_n) << 2);
        r_idx       <= '0;
      end

      if (w_out_fire) begin
        r_idx <= r_idx + ONE;
        if (w_idx_last && !w_final) begin
          r_chunk_n  <= chunk_len(r_remaining);
          r_sdr_base <= r_base;
        end
      end
    end
  end

  assign cmd_ready     = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign sdr_readstart = (r_state == S_ISSUE);
  assign sdr_baseaddr  = r_sdr_base;
  assign sdr_nelems    = 30'(r_chunk_n);
  assign out_valid     = (r_state == S_DRAIN);
  assign out_data      = r_buf[r_idx[AW-1:0]];
  assign out_last      = out_valid && w_idx_last && w_final;
  assign done          = r_done;

endmodule

// File: tb/tb_sdr_read_streamer.sv
// Directed bench for sdr_read_streamer with a small behavioural model of the burst engine.
module tb_sdr_read_streamer;

  localparam int MAXN = 64;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic [31:0]         cmd_baseaddr = '0;
  logic [29:0]         cmd_nwords = '0;
  logic [31:0]         sdr_baseaddr;
  logic [29:0]         sdr_nelems;
  logic                sdr_readstart;
  logic                sdr_readend;
  logic [32*MAXN-1:0]  sdr_readdata;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [31:0]         out_data;
  logic                out_last;
  logic                busy;
  logic                done;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  sdr_read_streamer #(.MAX_NREAD(MAXN)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_baseaddr(cmd_baseaddr), .cmd_nwords(cmd_nwords),
    .sdr_baseaddr(sdr_baseaddr), .sdr_nelems(sdr_nelems),
    .sdr_readstart(sdr_readstart), .sdr_readend(sdr_readend),
    .sdr_readdata(sdr_readdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: word i of a chunk at byte address a holds eng_seed + (a + 4i - eng_cmd_base)/4.
  logic [31:0] eng_cmd_base = '0;
  logic [31:0] eng_seed = '0;
  logic [31:0] st_base[$];
  int          st_n[$];
  int          st_cyc[$];
  int          rend_cyc[$];
  int          dbl_rs = 0;

  initial begin : engine
    logic        pending;
    logic        prev_rs;
    int          lat;
    int          n;
    logic [31:0] a;
    pending = 1'b0; prev_rs = 1'b0; lat = 0; n = 0; a = '0;
    sdr_readend = 1'b0;
    sdr_readdata = '0;
    forever begin
      @(negedge clk);
      sdr_readend = 1'b0;
      if (!reset) begin
        pending = 1'b0;
        prev_rs = 1'b0;
      end else begin
        if (pending) begin
          if (lat == 0) begin
            for (int i = 0; i < MAXN; i++)
              sdr_readdata[32*i +: 32] = (i < n) ? eng_seed + ((a + 32'(4*i) - eng_cmd_base) >> 2)
                                                 : 32'hDEAD_0000 + 32'(i);
            sdr_readend = 1'b1;
            pending = 1'b0;
            rend_cyc.push_back(cyc);
          end else lat--;
        end
        if (sdr_readstart) begin
          if (prev_rs) dbl_rs++;
          if (!pending) begin
            pending = 1'b1;
            lat = 2;
            a = sdr_baseaddr;
            n = int'(sdr_nelems);
            st_base.push_back(a);
            st_n.push_back(n);
            st_cyc.push_back(cyc);
          end
        end
        prev_rs = sdr_readstart;
      end
    end
  end

  logic [31:0] got_d[$];
  logic        got_l[$];
  int          got_c[$];
  bit          rdy_pat[$];
  int          done_cyc, n_valid, stall_bad, early_rdy;
  bit          tmo;

  task automatic clear_engine_log();
    st_base.delete(); st_n.delete(); st_cyc.delete(); rend_cyc.delete();
  endtask

  task automatic send_cmd(input logic [31:0] b, input logic [29:0] n, output int hs);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_baseaddr = b; cmd_nwords = n;
    hs = -1;
    for (int k = 0; k < 50; k++) begin
      if (cmd_ready) begin hs = cyc; break; end
      @(negedge clk);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Samples at negedges (starting with the current one) until done or the budget runs out.
  task automatic collect(input int max_cyc);
    logic        prev_stall;
    logic [31:0] prev_d;
    bit          r;
    got_d.delete(); got_l.delete(); got_c.delete();
    done_cyc = -1; n_valid = 0; stall_bad = 0; early_rdy = 0; tmo = 1'b1;
    prev_stall = 1'b0; prev_d = '0;
    for (int k = 0; k < max_cyc; k++) begin
      if (done) begin done_cyc = cyc; tmo = 1'b0; break; end
      if (cmd_ready) early_rdy++;
      if (out_valid) begin
        n_valid++;
        if (prev_stall && out_data !== prev_d) stall_bad++;
        r = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
        out_ready = r;
        if (r) begin got_d.push_back(out_data); got_l.push_back(out_last); got_c.push_back(cyc); end
        prev_stall = !r;
        prev_d = out_data;
      end else begin
        out_ready = 1'b1;
        prev_stall = 1'b0;
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sdr_readstart !== 1'b0) begin
      bad++; $display("FAIL rst_ctrl got v=%b b=%b d=%b rs=%b want all 0", out_valid, busy, done, sdr_readstart); end
    total++; if (sdr_baseaddr !== 32'h0 || sdr_nelems !== 30'h0 || out_data !== 32'h0 || out_last !== 1'b0) begin
      bad++; $display("FAIL rst_data got ba=%h ne=%h od=%h ol=%b want 0", sdr_baseaddr, sdr_nelems, out_data, out_last); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_idle got cmd_ready=%b busy=%b want 1 0", cmd_ready, busy); end
  endtask

  task automatic test_basic();
    int hs;
    clear_engine_log(); eng_seed = 32'hA; eng_cmd_base = 32'h1000;
    send_cmd(32'h1000, 30'd3, hs);
    collect(100);
    total++; if (st_n.size() != 1) begin bad++; $display("FAIL basic_nstart got=%0d want=1", st_n.size()); end
    if (st_n.size() >= 1) begin
      total++; if (st_n[0] != 3 || st_base[0] !== 32'h1000) begin
        bad++; $display("FAIL basic_cmd got n=%0d base=%h want 3 00001000", st_n[0], st_base[0]); end
      total++; if (st_cyc[0] != hs + 1) begin bad++; $display("FAIL basic_start_lat got=%0d want=%0d", st_cyc[0], hs + 1); end
    end
    total++; if (got_d.size() != 3) begin bad++; $display("FAIL basic_count got=%0d want=3", got_d.size()); end
    if (got_d.size() == 3) begin
      total++; if (got_d[0] !== 32'hA || got_d[1] !== 32'hB || got_d[2] !== 32'hC) begin
        bad++; $display("FAIL basic_data got=%h %h %h want=a b c", got_d[0], got_d[1], got_d[2]); end
      total++; if (got_l[0] !== 1'b0 || got_l[1] !== 1'b0 || got_l[2] !== 1'b1) begin
        bad++; $display("FAIL basic_last got=%b%b%b want=001", got_l[0], got_l[1], got_l[2]); end
      total++; if (got_c[2] - got_c[0] != 2) begin bad++; $display("FAIL basic_rate got=%0d want=2", got_c[2] - got_c[0]); end
      if (rend_cyc.size() >= 1) begin
        total++; if (got_c[0] != rend_cyc[0] + 1) begin
          bad++; $display("FAIL basic_rend_lat got=%0d want=%0d", got_c[0], rend_cyc[0] + 1); end
      end
      total++; if (done_cyc != got_c[2] + 1) begin bad++; $display("FAIL basic_done got=%0d want=%0d", done_cyc, got_c[2] + 1); end
    end
    total++; if (tmo) begin bad++; $display("FAIL basic_timeout got=1 want=0"); end
  endtask

  task automatic test_multi_chunk();
    int hs, errs, nlast;
    clear_engine_log(); eng_seed = 32'h100; eng_cmd_base = 32'h0;
    send_cmd(32'h0, 30'd130, hs);
    collect(2000);
    total++; if (st_n.size() != 3) begin bad++; $display("FAIL multi_nstart got=%0d want=3", st_n.size()); end
    if (st_n.size() == 3) begin
      total++; if (st_n[0] != 64 || st_n[1] != 64 || st_n[2] != 2) begin
        bad++; $display("FAIL multi_nelems got=%0d %0d %0d want=64 64 2", st_n[0], st_n[1], st_n[2]); end
      total++; if (st_base[0] !== 32'h0 || st_base[1] !== 32'h100 || st_base[2] !== 32'h200) begin
        bad++; $display("FAIL multi_base got=%h %h %h want=0 100 200", st_base[0], st_base[1], st_base[2]); end
    end
    total++; if (got_d.size() != 130) begin bad++; $display("FAIL multi_count got=%0d want=130", got_d.size()); end
    if (got_d.size() == 130) begin
      errs = 0; nlast = 0;
      for (int k = 0; k < 130; k++) begin
        if (got_d[k] !== 32'h100 + 32'(k)) errs++;
        if (got_l[k] === 1'b1) nlast++;
      end
      total++; if (errs != 0) begin bad++; $display("FAIL multi_data got=%0d wrong words want=0", errs); end
      total++; if (nlast != 1 || got_l[129] !== 1'b1) begin
        bad++; $display("FAIL multi_last got=%0d lasts, last129=%b want=1 1", nlast, got_l[129]); end
      total++; if (done_cyc != got_c[129] + 1) begin bad++; $display("FAIL multi_done got=%0d want=%0d", done_cyc, got_c[129] + 1); end
    end
    total++; if (dbl_rs != 0) begin bad++; $display("FAIL multi_double_start got=%0d want=0", dbl_rs); end
  endtask

  task automatic test_full_chunk();
    int hs, nlast;
    clear_engine_log(); eng_seed = 32'h1000; eng_cmd_base = 32'h6000;
    send_cmd(32'h6000, 30'd64, hs);
    collect(500);
    total++; if (st_n.size() != 1 || (st_n.size() == 1 && st_n[0] != 64)) begin
      bad++; $display("FAIL full_chunk got starts=%0d want one of 64", st_n.size()); end
    total++; if (got_d.size() != 64) begin bad++; $display("FAIL full_count got=%0d want=64", got_d.size()); end
    if (got_d.size() == 64) begin
      nlast = 0;
      for (int k = 0; k < 64; k++) if (got_l[k] === 1'b1) nlast++;
      total++; if (nlast != 1 || got_l[63] !== 1'b1 || got_d[63] !== 32'h103F) begin
        bad++; $display("FAIL full_last got lasts=%0d w63=%h want=1 0000103f", nlast, got_d[63]); end
    end
  endtask

  task automatic test_backpressure();
    int hs;
    clear_engine_log(); eng_seed = 32'h55; eng_cmd_base = 32'h800;
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    send_cmd(32'h800, 30'd4, hs);
    collect(200);
    total++; if (got_d.size() != 4) begin bad++; $display("FAIL bp_count got=%0d want=4", got_d.size()); end
    if (got_d.size() == 4) begin
      total++; if (got_d[0] !== 32'h55 || got_d[1] !== 32'h56 || got_d[2] !== 32'h57 || got_d[3] !== 32'h58) begin
        bad++; $display("FAIL bp_data got=%h %h %h %h want=55 56 57 58", got_d[0], got_d[1], got_d[2], got_d[3]); end
      total++; if (got_c[1] - got_c[0] != 3 || got_c[2] - got_c[0] != 5 || got_c[3] - got_c[0] != 6) begin
        bad++; $display("FAIL bp_timing got=%0d %0d %0d want=3 5 6", got_c[1] - got_c[0], got_c[2] - got_c[0], got_c[3] - got_c[0]); end
      total++; if (got_l[3] !== 1'b1 || got_l[2] !== 1'b0) begin bad++; $display("FAIL bp_last got=%b%b want=01", got_l[2], got_l[3]); end
    end
    total++; if (stall_bad != 0) begin bad++; $display("FAIL bp_stable got=%0d changes want=0", stall_bad); end
    total++; if (n_valid != 7) begin bad++; $display("FAIL bp_valid_cycles got=%0d want=7", n_valid); end
  endtask

  task automatic test_zero_length();
    int hs;
    clear_engine_log();
    send_cmd(32'h40, 30'd0, hs);
    collect(20);
    total++; if (done_cyc != hs + 1) begin bad++; $display("FAIL zero_done got=%0d want=%0d", done_cyc, hs + 1); end
    total++; if (n_valid != 0) begin bad++; $display("FAIL zero_valid got=%0d want=0", n_valid); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_pulse got=%b want=0", done); end
    repeat (5) @(negedge clk);
    total++; if (st_n.size() != 0) begin bad++; $display("FAIL zero_start got=%0d want=0", st_n.size()); end
  endtask

  task automatic test_back_to_back();
    int hs, hs2;
    clear_engine_log(); eng_seed = 32'h700; eng_cmd_base = 32'h2000;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_baseaddr = 32'h2000; cmd_nwords = 30'd5;
    hs = cyc;
    @(negedge clk);
    cmd_baseaddr = 32'h3000; cmd_nwords = 30'd2;
    collect(300);
    total++; if (got_d.size() != 5 || (got_d.size() == 5 && (got_d[0] !== 32'h700 || got_d[4] !== 32'h704))) begin
      bad++; $display("FAIL b2b_first got count=%0d want=5 words 700..704", got_d.size()); end
    total++; if (early_rdy != 0) begin bad++; $display("FAIL b2b_cmd_ready got=%0d busy cycles with ready want=0", early_rdy); end
    total++; if (st_n.size() != 1) begin bad++; $display("FAIL b2b_held got=%0d starts before done want=1", st_n.size()); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_after got=%b want=1", cmd_ready); end
    hs2 = cyc; eng_cmd_base = 32'h3000; eng_seed = 32'h900;
    @(negedge clk);
    cmd_valid = 1'b0;
    collect(300);
    total++; if (st_n.size() != 2) begin bad++; $display("FAIL b2b_second got=%0d starts want=2", st_n.size()); end
    if (st_n.size() == 2) begin
      total++; if (st_base[1] !== 32'h3000 || st_n[1] != 2 || st_cyc[1] != hs2 + 1) begin
        bad++; $display("FAIL b2b_second_cmd got base=%h n=%0d cyc=%0d want 3000 2 %0d", st_base[1], st_n[1], st_cyc[1], hs2 + 1); end
    end
    total++; if (got_d.size() != 2 || (got_d.size() == 2 && (got_d[0] !== 32'h900 || got_d[1] !== 32'h901))) begin
      bad++; $display("FAIL b2b_second_data got count=%0d want=2 words 900 901", got_d.size()); end
    if (hs < 0) $display("note: hs unused");
  endtask

  task automatic test_reset_mid_drain();
    int hs;
    clear_engine_log(); eng_seed = 32'h33; eng_cmd_base = 32'h4000;
    send_cmd(32'h4000, 30'd64, hs);
    out_ready = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (out_valid) break;
      @(negedge clk);
    end
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b1 || out_data !== 32'h3D) begin
      bad++; $display("FAIL rstmid_pre got v=%b d=%h want 1 0000003d", out_valid, out_data); end
    #2 reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || busy !== 1'b0 || sdr_readstart !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL rstmid_async got v=%b b=%b rs=%b d=%b want 0 0 0 0", out_valid, busy, sdr_readstart, done); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rstmid_buf got=%h want=0", out_data); end
    @(negedge clk);
    #2 reset = 1'b1;
    out_ready = 1'b1;
    clear_engine_log(); eng_seed = 32'h77; eng_cmd_base = 32'h5000;
    send_cmd(32'h5000, 30'd1, hs);
    collect(100);
    total++; if (st_n.size() != 1 || (st_n.size() == 1 && (st_n[0] != 1 || st_base[0] !== 32'h5000))) begin
      bad++; $display("FAIL rstmid_cmd got starts=%0d want one start n=1 base 5000", st_n.size()); end
    total++; if (got_d.size() != 1 || (got_d.size() == 1 && (got_d[0] !== 32'h77 || got_l[0] !== 1'b1))) begin
      bad++; $display("FAIL rstmid_word got count=%0d want one word 77 with last", got_d.size()); end
    total++; if (tmo) begin bad++; $display("FAIL rstmid_done got timeout want done"); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_multi_chunk();
    test_full_chunk();
    test_backpressure();
    test_zero_length();
    test_back_to_back();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
